// File: rtl/csa42_accumulator.sv
// ---------------------------------------------------------------------------
// csa42_accumulator
//
// Streaming multi-operand accumulator. Each accepted beat adds two operands
// into a carry-save state (acc_sum, acc_carry) through one row of 4:2
// compressors. The last beat of a transaction triggers a single
// carry-propagate add. The result is then held on a valid/ready port until
// the consumer takes it.
//
// Optional feature macro: CSA42_BEATS_EN
//   When defined, a saturating 16-bit beat counter is kept. Its value is
//   reported on beats_o together with each result.
//
// Parameters
//   WIDTH      operand width in bits
//   GUARD      guard bits above WIDTH; ACC_WIDTH = WIDTH + GUARD
//
// Ports
//   clk_i        clock, all state changes on the rising edge
//   rstn_i       synchronous active-low reset
//   in_valid_i   operand beat valid
//   in_ready_o   block can accept a beat (state ACCUM)
//   in_last_i    beat is the last of the transaction
//   signed_i     1: sign-extend a_i/b_i, 0: zero-extend (per beat)
//   a_i, b_i     operands
//   res_valid_o  result valid (state HOLD)
//   res_ready_i  consumer accepts the result
//   res_o        accumulated result, modulo 2^ACC_WIDTH
//   beats_o      beat count of the result (CSA42_BEATS_EN only)
// ---------------------------------------------------------------------------
module csa42_accumulator #(
    parameter int WIDTH = 32,
    parameter int GUARD = 8,
    localparam int ACC_WIDTH = WIDTH + GUARD
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic                 in_last_i,
    input  logic                 signed_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic                 res_valid_o,
    input  logic                 res_ready_i,
    output logic [ACC_WIDTH-1:0] res_o
`ifdef CSA42_BEATS_EN
    ,
    output logic [15:0]          beats_o
`endif
);

    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        RESOLVE = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t state, state_next;

    logic [ACC_WIDTH-1:0] acc_sum;
    logic [ACC_WIDTH-1:0] acc_carry;
    logic [ACC_WIDTH-1:0] ext_a;
    logic [ACC_WIDTH-1:0] ext_b;
    logic [ACC_WIDTH-1:0] cell_s1;
    logic [ACC_WIDTH-1:0] cell_cin;
    logic [ACC_WIDTH-1:0] cell_sum;
    logic [ACC_WIDTH-2:0] cell_cout;
    logic [ACC_WIDTH-2:0] cell_carry;
    logic                 beat_accept;

    assign beat_accept = in_valid_i & in_ready_o;

    // Each beat is extended on its own signed_i, so signed and unsigned
    // beats may be mixed within one transaction.
    assign ext_a = signed_i ? {{GUARD{a_i[WIDTH-1]}}, a_i} : {{GUARD{1'b0}}, a_i};
    assign ext_b = signed_i ? {{GUARD{b_i[WIDTH-1]}}, b_i} : {{GUARD{1'b0}}, b_i};

    // Row of 4:2 cells, written bit-parallel. The cout of cell k feeds the
    // cin of cell k+1 only. It depends on x2..x4 and never on cin, so there
    // is no ripple along the row. The MSB cout and MSB carry are simply not
    // generated. This drops them and gives the modulo-2^ACC_WIDTH wrap.
    assign cell_cout  = (acc_sum[ACC_WIDTH-2:0] & ext_a[ACC_WIDTH-2:0])
                      | (acc_sum[ACC_WIDTH-2:0] & ext_b[ACC_WIDTH-2:0])
                      | (ext_a[ACC_WIDTH-2:0]   & ext_b[ACC_WIDTH-2:0]);
    assign cell_cin   = {cell_cout, 1'b0};
    assign cell_s1    = ~(acc_sum ^ ext_a ^ ext_b);
    assign cell_sum   = ~(cell_s1 ^ (acc_carry ^ cell_cin));
    assign cell_carry = (cell_s1[ACC_WIDTH-2:0]
                            & (cell_cin[ACC_WIDTH-2:0] & acc_carry[ACC_WIDTH-2:0]))
                      | (~cell_s1[ACC_WIDTH-2:0]
                            & (cell_cin[ACC_WIDTH-2:0] | acc_carry[ACC_WIDTH-2:0]));

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state <= ACCUM;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. The handshake outputs are decoded from the state
    // register only, so no input reaches them combinationally.
    always_comb begin
        state_next  = state;
        in_ready_o  = 1'b0;
        res_valid_o = 1'b0;
        case (state)
            ACCUM: begin
                in_ready_o = 1'b1;
                if (beat_accept && in_last_i) begin
                    state_next = RESOLVE;
                end
            end
            RESOLVE: begin
                state_next = HOLD;
            end
            HOLD: begin
                res_valid_o = 1'b1;
                if (res_ready_i) begin
                    state_next = ACCUM;
                end
            end
            default: begin
                state_next = ACCUM;
            end
        endcase
    end

    // Carry-save state and result register. The carry-save pair is cleared
    // as soon as it has been resolved. It is therefore already zero when the
    // next transaction starts after the handoff.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            acc_sum   <= '0;
            acc_carry <= '0;
            res_o     <= '0;
        end else begin
            case (state)
                ACCUM: begin
                    if (beat_accept) begin
                        acc_sum   <= cell_sum;
                        acc_carry <= {cell_carry, 1'b0};
                    end
                end
                RESOLVE: begin
                    res_o     <= acc_sum + acc_carry;
                    acc_sum   <= '0;
                    acc_carry <= '0;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef CSA42_BEATS_EN
    logic [15:0] beat_count;

    // Saturating beat counter. It is latched into beats_o alongside the
    // result and restarts once the result has been handed off.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            beat_count <= '0;
            beats_o    <= '0;
        end else begin
            if (beat_accept && (beat_count != 16'hFFFF)) begin
                beat_count <= beat_count + 16'd1;
            end
            if (state == RESOLVE) begin
                beats_o <= beat_count;
            end
            if ((state == HOLD) && res_ready_i) begin
                beat_count <= '0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_csa42_accumulator.sv
// ---------------------------------------------------------------------------
// tb_csa42_accumulator
//
// Directed testbench for csa42_accumulator with WIDTH=8 and GUARD=8.
// applyStimulus drives one beat. For each transaction, the hand-computed
// expected result is pushed into exp_q. A monitor pops an entry and checks
// it against res_o (and beats_o when enabled) at every result handoff.
// ---------------------------------------------------------------------------
module tb_csa42_accumulator;

    localparam int WIDTH     = 8;
    localparam int GUARD     = 8;
    localparam int ACC_WIDTH = WIDTH + GUARD;

    logic                 clk = 1'b0;
    logic                 rstn_i;
    logic                 in_valid_i;
    logic                 in_ready_o;
    logic                 in_last_i;
    logic                 signed_i;
    logic [WIDTH-1:0]     a_i;
    logic [WIDTH-1:0]     b_i;
    logic                 res_valid_o;
    logic                 res_ready_i;
    logic [ACC_WIDTH-1:0] res_o;
`ifdef CSA42_BEATS_EN
    logic [15:0]          beats_o;
`endif

    typedef struct packed {
        logic [15:0] res;
        logic [15:0] beats;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    csa42_accumulator #(.WIDTH(WIDTH), .GUARD(GUARD)) dut (
        .clk_i       (clk),
        .rstn_i      (rstn_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_last_i   (in_last_i),
        .signed_i    (signed_i),
        .a_i         (a_i),
        .b_i         (b_i),
        .res_valid_o (res_valid_o),
        .res_ready_i (res_ready_i),
        .res_o       (res_o)
`ifdef CSA42_BEATS_EN
        ,
        .beats_o     (beats_o)
`endif
    );

    always #5 clk = ~clk;

    // One comparison: counts it and reports a mismatch.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // A bounded wait that expired counts as a failed comparison.
    task automatic reportTimeout(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s: got timeout expected event", name);
    endtask

    // Drives one beat and returns 1ns after the edge that accepted it.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                                 input logic sgn, input logic last);
        int waited = 0;
        @(negedge clk);
        while (!in_ready_o && waited < 64) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready_o) begin
            reportTimeout("beat_ready_wait");
            return;
        end
        a_i        = a;
        b_i        = b;
        signed_i   = sgn;
        in_last_i  = last;
        in_valid_i = 1'b1;
        @(posedge clk);
        #1;
        in_valid_i = 1'b0;
        in_last_i  = 1'b0;
    endtask

    task automatic expectResult(input logic [15:0] res, input logic [15:0] beats);
        exp_t e;
        e.res   = res;
        e.beats = beats;
        exp_q.push_back(e);
    endtask

    // Returns 1ns after the edge on which res_valid_o rose.
    task automatic waitValid(input string name);
        int waited = 0;
        while (!res_valid_o && waited < 64) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (!res_valid_o) reportTimeout(name);
    endtask

    task automatic waitDrain(input string name);
        int waited = 0;
        while (exp_q.size() != 0 && waited < 64) begin
            @(negedge clk);
            waited++;
        end
        if (exp_q.size() != 0) reportTimeout(name);
    endtask

    // Monitor: checks every result handoff against the scoreboard.
    always @(negedge clk) begin
        if (rstn_i && res_valid_o && res_ready_i) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_result: got 0x%0h expected none", res_o);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("res_o", 32'(res_o), 32'(mon_e.res));
`ifdef CSA42_BEATS_EN
                checkOutput("beats_o", 32'(beats_o), 32'(mon_e.beats));
`endif
            end
        end
    end

    initial begin
        #5_000_000;
        bad++;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int drops;
        int valid_seen;

        rstn_i      = 1'b0;
        in_valid_i  = 1'b0;
        in_last_i   = 1'b0;
        signed_i    = 1'b0;
        a_i         = '0;
        b_i         = '0;
        res_ready_i = 1'b1;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_in_ready", 32'(in_ready_o), 32'd1);
        checkOutput("rst_res_valid", 32'(res_valid_o), 32'd0);
        checkOutput("rst_res_o", 32'(res_o), 32'd0);
`ifdef CSA42_BEATS_EN
        checkOutput("rst_beats_o", 32'(beats_o), 32'd0);
`endif
        rstn_i = 1'b1;

        // Single unsigned beat: 0xFF + 0x01 = 0x0100. Valid rises on the
        // second edge after acceptance.
        $display("[TB] single beat");
        applyStimulus(8'hFF, 8'h01, 1'b0, 1'b1);
        expectResult(16'h0100, 16'd1);
        checkOutput("lat_ready_low", 32'(in_ready_o), 32'd0);
        checkOutput("lat_edge1_valid", 32'(res_valid_o), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("lat_edge2_valid", 32'(res_valid_o), 32'd1);
        waitDrain("single_drain");

        // Signed: -128 + -1 + 1 + 0 = -128 = 0xFF80.
        $display("[TB] signed beats");
        applyStimulus(8'h80, 8'hFF, 1'b1, 1'b0);
        applyStimulus(8'h01, 8'h00, 1'b1, 1'b1);
        expectResult(16'hFF80, 16'd2);
        waitDrain("signed_drain");

        // 300 x (255 + 255) = 153000, modulo 65536 = 0x55A8.
        $display("[TB] 300 back-to-back beats");
        drops = 0;
        for (int i = 1; i <= 300; i++) begin
            applyStimulus(8'hFF, 8'hFF, 1'b0, (i == 300));
            if (i < 300 && !in_ready_o) drops++;
        end
        expectResult(16'h55A8, 16'd300);
        checkOutput("stream_ready_drops", 32'(drops), 32'd0);
        waitDrain("stream_drain");

        // Mixed extension with backpressure: signed (-1 + 1) then
        // unsigned (255 + 255) = 0x01FE, held while res_ready_i is low.
        $display("[TB] result backpressure");
        res_ready_i = 1'b0;
        applyStimulus(8'hFF, 8'h01, 1'b1, 1'b0);
        applyStimulus(8'hFF, 8'hFF, 1'b0, 1'b1);
        expectResult(16'h01FE, 16'd2);
        waitValid("hold_valid_wait");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("hold_res_o", 32'(res_o), 32'h01FE);
            checkOutput("hold_in_ready", 32'(in_ready_o), 32'd0);
            checkOutput("hold_res_valid", 32'(res_valid_o), 32'd1);
        end
        @(posedge clk);
        #1;
        res_ready_i = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("handoff_in_ready", 32'(in_ready_o), 32'd1);
        checkOutput("handoff_res_valid", 32'(res_valid_o), 32'd0);
        waitDrain("hold_drain");

        // Reset after 3 beats aborts the transaction; the next one starts
        // clean: 2 + 3 = 5.
        $display("[TB] reset mid-transaction");
        for (int i = 0; i < 3; i++) applyStimulus(8'h01, 8'h01, 1'b0, 1'b0);
        @(negedge clk);
        rstn_i = 1'b0;
        @(posedge clk);
        #1;
        rstn_i = 1'b1;
        checkOutput("abort_in_ready", 32'(in_ready_o), 32'd1);
        checkOutput("abort_res_o", 32'(res_o), 32'd0);
        valid_seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (res_valid_o) valid_seen++;
        end
        checkOutput("abort_no_valid", 32'(valid_seen), 32'd0);
        applyStimulus(8'h02, 8'h03, 1'b0, 1'b1);
        expectResult(16'h0005, 16'd1);
        waitDrain("abort_drain");

`ifdef CSA42_BEATS_EN
        // Four beats of 1 + 1 = 8.
        $display("[TB] beat counter");
        for (int i = 1; i <= 4; i++) applyStimulus(8'h01, 8'h01, 1'b0, (i == 4));
        expectResult(16'h0008, 16'd4);
        waitDrain("beats4_drain");

        // 70000 zero beats saturate the counter.
        $display("[TB] beat counter saturation");
        for (int i = 1; i <= 70000; i++) applyStimulus(8'h00, 8'h00, 1'b0, (i == 70000));
        expectResult(16'h0000, 16'hFFFF);
        waitDrain("beats_sat_drain");
`endif

        repeat (4) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/csa42_accumulator.md
# csa42_accumulator

- Streaming multi-operand accumulator built from a parametrised row of 4:2 compressors.
- Absorbs two operands per accepted beat into a carry-save state (sum, carry).
- Runs one carry-propagate resolve per transaction, then presents the result on a valid/ready port.
- Sits in the Integer ALU as the reduction back end for dot-product and multi-operand-add instructions.

## Interface
- WIDTH, 32, operand width in bits
- GUARD, 8, guard bits added above WIDTH; ACC_WIDTH = WIDTH + GUARD
- clk_i  input  1  clock, all state changes on rising edge
- rstn_i  input  1  synchronous active-low reset, sampled on rising clk_i
- in_valid_i  input  1  operand beat valid
- in_ready_o  output  1  block can accept a beat
- in_last_i  input  1  beat is the last of the transaction
- signed_i  input  1  1: sign-extend a_i/b_i to ACC_WIDTH; 0: zero-extend; sampled per beat
- a_i  input  WIDTH  operand A
- b_i  input  WIDTH  operand B
- res_valid_o  output  1  result valid
- res_ready_i  input  1  consumer accepts result
- res_o  output  ACC_WIDTH  accumulated result, two's complement, modulo 2^ACC_WIDTH
- beats_o  output  16  beat count of the result (only with CSA42_BEATS_EN)

## Operation
- State machine: ACCUM, RESOLVE, HOLD. Reset state: ACCUM.
- Carry-save state: acc_sum and acc_carry, each ACC_WIDTH bits. Both are 0 after reset and after every result handoff.
- ACCUM:
  - in_ready_o = 1. A beat is accepted when in_valid_i & in_ready_o.
  - Per accepted beat, for each bit k, a 4:2 cell takes x1=acc_carry[k], x2=acc_sum[k], x3=ext(a)[k], x4=ext(b)[k] and cin=cout[k-1]. cin[0] = 0.
  - Per cell: cout = maj(x2,x3,x4); s1 = ~(x2^x3^x4); sum = ~(s1^(x1^cin)); carry = s1 ? (cin&x1) : (cin|x1).
  - New acc_sum = sum vector. New acc_carry = {carry[ACC_WIDTH-2:0], 1'b0}.
  - Bits shifted out at the MSB (carry[ACC_WIDTH-1], cout[ACC_WIDTH-1]) are discarded, giving modulo-2^ACC_WIDTH wrap.
  - Accepted beat with in_last_i = 1: update the state, then go to RESOLVE.
- RESOLVE:
  - in_ready_o = 0.
  - res_o register <= acc_sum + acc_carry (ACC_WIDTH bits, carry out dropped).
  - Clear acc_sum/acc_carry; go to HOLD.
- HOLD:
  - res_valid_o = 1; in_ready_o = 0; res_o stable.
  - When res_ready_i = 1, go to ACCUM.
- Every transaction holds at least one beat. An all-zero result needs a beat with a_i = b_i = 0.
- Reset outputs: in_ready_o = 1 (state ACCUM), res_valid_o = 0, res_o = 0, beats_o = 0.
- Reset mid-transaction or during HOLD:
  - Discard the partial sums and any pending result.
  - No res_valid_o for the aborted transaction.
- in_valid_i with in_ready_o = 0: not accepted. The producer holds its data; the block samples nothing.
- signed_i may differ between beats; each beat is extended according to its own signed_i.

## Timing
- in_ready_o and res_valid_o are decoded from registered state only; no combinational path from any input.
- Last beat accepted at edge t:
  - RESOLVE during cycle t..t+1.
  - res_valid_o = 1 after edge t+1, i.e. visible in the cycle after RESOLVE.
- Latency from last-beat acceptance to result valid: 2 cycles.
- Result accepted at edge u (res_valid_o & res_ready_i): res_valid_o = 0 and in_ready_o = 1 after edge u.
- Throughput:
  - One beat per cycle in ACCUM.
  - Minimum 2 dead cycles per transaction (RESOLVE + at least one HOLD cycle).
- Critical path: one 4:2 cell row (the cin ripple spans one bit only) in ACCUM; ACC_WIDTH-bit adder in RESOLVE.

## Configuration
- CSA42_BEATS_EN defined:
  - beats_o present.
  - Internal 16-bit counter increments per accepted beat and saturates at 0xFFFF.
  - Copied into the beats_o register in RESOLVE; cleared on reset and on result handoff.
- Undefined: the beats_o port and the counter are absent; all other behaviour is identical.

## Test plan
- WIDTH=8, GUARD=8. Single beat a=0xFF, b=0x01, signed_i=0, last -> res_o=0x0100, res_valid_o exactly 2 cycles after acceptance.
- Signed beats (a=0x80, b=0xFF), then (a=0x01, b=0x00, last), signed_i=1 -> res_o=0xFF80 (-128).
- 300 back-to-back beats, a=b=0xFF unsigned, last on beat 300 -> res_o=0x55A8 (153000 mod 65536); in_ready_o high throughout ACCUM.
- Hold res_ready_i=0 for 5 cycles after res_valid_o -> res_o stable and in_ready_o=0 for all 5; in_ready_o=1 the cycle after res_ready_i=1.
- Assert rstn_i=0 for one edge after 3 beats of a transaction -> res_valid_o never rises for it; next transaction a=0x02, b=0x03, last -> res_o=0x0005.
- With CSA42_BEATS_EN: 4 beats -> beats_o=4 with res_valid_o; 70000 beats -> beats_o=0xFFFF.
